// File: rtl/gat_ctrl_pkg.sv
// gat_ctrl_pkg: shared FSM states, region encoding and error codes for the GAT load sequencer
package gat_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_CORE = 3'd2,
        S_DONE      = 3'd3,
        S_ERR       = 3'd4
    } state_e;
    localparam logic [1:0] REG_H_DATA    = 2'd0;
    localparam logic [1:0] REG_NODE_INFO = 2'd1;
    localparam logic [1:0] REG_WGT       = 2'd2;
    localparam logic [1:0] REG_SUBGRAPH  = 2'd3;
    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd2;
endpackage

// File: rtl/gat_region_counter.sv
// gat_region_counter: per-region word index that stops at DEPTH and flags the region complete
module gat_region_counter #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] idx,
    output logic              complete
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // advance on each written word, holding once the region is full
    always_comb begin
        cnt_d = clr ? '0 : (inc && !complete) ? cnt_q + CW'(1) : cnt_q;
    end
    // index register
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign complete = cnt_q == CW'(DEPTH);
    assign idx      = cnt_q[ADDR_W-1:0];
endmodule

// File: rtl/gat_load_ctrl.sv
// gat_load_ctrl: host word stream to per-region BRAM writes, then supervises the core run
module gat_load_ctrl
    import gat_ctrl_pkg::*;
#(
    parameter int TOP_WIDTH       = 32,
    parameter int H_DATA_DEPTH    = 242101,
    parameter int NODE_INFO_DEPTH = 13264,
    parameter int WEIGHT_DEPTH    = 22928,
    parameter int SUBGRAPH_DEPTH  = 13264,
    parameter int TIMEOUT_CYCLES  = 50000000,
    parameter int H_ADDR_W        = $clog2(H_DATA_DEPTH),
    parameter int N_ADDR_W        = $clog2(NODE_INFO_DEPTH),
    parameter int W_ADDR_W        = $clog2(WEIGHT_DEPTH),
    parameter int S_ADDR_W        = $clog2(SUBGRAPH_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic                 host_valid,
    output logic                 host_ready,
    input  logic [1:0]           host_sel,
    input  logic [TOP_WIDTH-1:0] host_data,
    output logic [TOP_WIDTH-1:0] h_data_bram_din,
    output logic                 h_data_bram_ena,
    output logic                 h_data_bram_wea,
    output logic [H_ADDR_W+1:0]  h_data_bram_addra,
    output logic [TOP_WIDTH-1:0] h_node_info_bram_din,
    output logic                 h_node_info_bram_ena,
    output logic                 h_node_info_bram_wea,
    output logic [N_ADDR_W+1:0]  h_node_info_bram_addra,
    output logic [TOP_WIDTH-1:0] wgt_bram_din,
    output logic                 wgt_bram_ena,
    output logic                 wgt_bram_wea,
    output logic [W_ADDR_W+1:0]  wgt_bram_addra,
    output logic [TOP_WIDTH-1:0] subgraph_bram_din,
    output logic                 subgraph_bram_ena,
    output logic                 subgraph_bram_wea,
    output logic [S_ADDR_W+1:0]  subgraph_bram_addra,
    output logic                 h_data_bram_load_done,
    output logic                 h_node_info_bram_load_done,
    output logic                 wgt_bram_load_done,
    input  logic                 core_ready,
    output logic                 sts_busy,
    output logic                 sts_done,
    output logic                 sts_err,
    output logic [1:0]           sts_err_code,
    output logic [2:0]           dbg_state,
    output logic [TOP_WIDTH-1:0] dbg_words,
    output logic [TOP_WIDTH-1:0] dbg_cycles
);
    state_e                state_q, state_d;
    logic [3:0]            complete, wr_q;
    logic                  accept, overflow, write, enter_load, clr_cnt, core_rise, rdy_q;
    logic [H_ADDR_W-1:0]   h_idx;
    logic [N_ADDR_W-1:0]   n_idx;
    logic [W_ADDR_W-1:0]   w_idx;
    logic [S_ADDR_W-1:0]   s_idx;
    logic [H_ADDR_W+1:0]   h_addr_q;
    logic [N_ADDR_W+1:0]   n_addr_q;
    logic [W_ADDR_W+1:0]   w_addr_q;
    logic [S_ADDR_W+1:0]   s_addr_q;
    logic [TOP_WIDTH-1:0]  din_q, words_q, cycles_q;
    logic [2:0]            load_done_q;
    logic [1:0]            err_q;

    assign accept     = host_ready && host_valid;
    assign overflow   = accept && complete[host_sel];
    assign write      = accept && !complete[host_sel];
    assign enter_load = state_d == S_LOAD && state_q != S_LOAD;
    assign clr_cnt    = enter_load || cfg_abort;
    assign core_rise  = core_ready && !rdy_q;

    gat_region_counter #(.DEPTH(H_DATA_DEPTH), .ADDR_W(H_ADDR_W)) u_cnt_h (
        .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(write && host_sel == REG_H_DATA),
        .idx(h_idx), .complete(complete[0]));
    gat_region_counter #(.DEPTH(NODE_INFO_DEPTH), .ADDR_W(N_ADDR_W)) u_cnt_n (
        .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(write && host_sel == REG_NODE_INFO),
        .idx(n_idx), .complete(complete[1]));
    gat_region_counter #(.DEPTH(WEIGHT_DEPTH), .ADDR_W(W_ADDR_W)) u_cnt_w (
        .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(write && host_sel == REG_WGT),
        .idx(w_idx), .complete(complete[2]));
    gat_region_counter #(.DEPTH(SUBGRAPH_DEPTH), .ADDR_W(S_ADDR_W)) u_cnt_s (
        .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(write && host_sel == REG_SUBGRAPH),
        .idx(s_idx), .complete(complete[3]));

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next state: abort overrides everything, overflow beats completion
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: if (cfg_start) state_d = S_LOAD;
            S_LOAD:                state_d = overflow ? S_ERR : (&complete) ? S_WAIT_CORE : S_LOAD;
            S_WAIT_CORE:           state_d = core_rise ? S_DONE :
                                             (cycles_q == TOP_WIDTH'(TIMEOUT_CYCLES - 1)) ? S_ERR : S_WAIT_CORE;
            default:               state_d = S_IDLE;
        endcase
        if (cfg_abort) state_d = S_IDLE;
    end

    // outputs decoded from state and the registered write stage
    always_comb begin
        host_ready                 = state_q == S_LOAD && !cfg_abort;
        sts_busy                   = state_q == S_LOAD || state_q == S_WAIT_CORE;
        sts_done                   = state_q == S_DONE;
        sts_err                    = state_q == S_ERR;
        sts_err_code               = err_q;
        dbg_state                  = state_q;
        dbg_words                  = words_q;
        dbg_cycles                 = cycles_q;
        h_data_bram_din            = din_q;
        h_data_bram_ena            = wr_q[0];
        h_data_bram_wea            = wr_q[0];
        h_data_bram_addra          = h_addr_q;
        h_node_info_bram_din       = din_q;
        h_node_info_bram_ena       = wr_q[1];
        h_node_info_bram_wea       = wr_q[1];
        h_node_info_bram_addra     = n_addr_q;
        wgt_bram_din               = din_q;
        wgt_bram_ena               = wr_q[2];
        wgt_bram_wea               = wr_q[2];
        wgt_bram_addra             = w_addr_q;
        subgraph_bram_din          = din_q;
        subgraph_bram_ena          = wr_q[3];
        subgraph_bram_wea          = wr_q[3];
        subgraph_bram_addra        = s_addr_q;
        h_data_bram_load_done      = load_done_q[0];
        h_node_info_bram_load_done = load_done_q[1];
        wgt_bram_load_done         = load_done_q[2];
    end

    // write demux stage, load_done levels, error code, ready sampling and debug counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q        <= '0;
            din_q       <= '0;
            h_addr_q    <= '0;
            n_addr_q    <= '0;
            w_addr_q    <= '0;
            s_addr_q    <= '0;
            rdy_q       <= 1'b0;
            load_done_q <= '0;
            err_q       <= ERR_NONE;
            words_q     <= '0;
            cycles_q    <= '0;
        end else begin
            wr_q        <= write ? 4'b0001 << host_sel : '0;
            if (write) din_q <= host_data;
            if (write && host_sel == REG_H_DATA)    h_addr_q <= {h_idx, 2'b00};
            if (write && host_sel == REG_NODE_INFO) n_addr_q <= {n_idx, 2'b00};
            if (write && host_sel == REG_WGT)       w_addr_q <= {w_idx, 2'b00};
            if (write && host_sel == REG_SUBGRAPH)  s_addr_q <= {s_idx, 2'b00};
            rdy_q       <= core_ready;
            load_done_q <= (enter_load || state_d == S_IDLE || state_d == S_ERR) ? '0 : complete[2:0];
            err_q       <= clr_cnt ? ERR_NONE : overflow ? ERR_OVERFLOW :
                           (state_q == S_WAIT_CORE && state_d == S_ERR) ? ERR_TIMEOUT : err_q;
            words_q     <= enter_load ? '0 : (accept && words_q != '1) ? words_q + TOP_WIDTH'(1) : words_q;
            cycles_q    <= enter_load ? '0 :
                           (state_q == S_WAIT_CORE && state_d == S_WAIT_CORE && cycles_q != '1) ?
                           cycles_q + TOP_WIDTH'(1) : cycles_q;
        end
    end
endmodule

// File: tb/tb_gat_load_ctrl.sv
// tb_gat_load_ctrl: directed tests of the load sequencer against a cycle model of its rules
module tb_gat_load_ctrl;
    localparam int IDLE = 0, LOAD = 1, WAIT = 2, DONE = 3, ERR = 4;
    localparam int TIMEOUT = 100;
    int dep[4] = '{5, 3, 4, 3};

    logic        clk = 0, rst_n = 0, cfg_start = 0, cfg_abort = 0, host_valid = 0, core_ready = 0;
    logic [1:0]  host_sel = 0;
    logic [31:0] host_data = 0;
    logic        host_ready;
    logic [31:0] h_din, n_din, w_din, s_din;
    logic        h_ena, h_wea, n_ena, n_wea, w_ena, w_wea, s_ena, s_wea;
    logic [4:0]  h_addr;
    logic [3:0]  n_addr, w_addr, s_addr;
    logic        h_ld, n_ld, w_ld, sts_busy, sts_done, sts_err;
    logic [1:0]  sts_err_code;
    logic [2:0]  dbg_state;
    logic [31:0] dbg_words, dbg_cycles;

    gat_load_ctrl #(
        .H_DATA_DEPTH(5), .NODE_INFO_DEPTH(3), .WEIGHT_DEPTH(4), .SUBGRAPH_DEPTH(3), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .host_valid(host_valid), .host_ready(host_ready), .host_sel(host_sel), .host_data(host_data),
        .h_data_bram_din(h_din), .h_data_bram_ena(h_ena), .h_data_bram_wea(h_wea), .h_data_bram_addra(h_addr),
        .h_node_info_bram_din(n_din), .h_node_info_bram_ena(n_ena), .h_node_info_bram_wea(n_wea),
        .h_node_info_bram_addra(n_addr),
        .wgt_bram_din(w_din), .wgt_bram_ena(w_ena), .wgt_bram_wea(w_wea), .wgt_bram_addra(w_addr),
        .subgraph_bram_din(s_din), .subgraph_bram_ena(s_ena), .subgraph_bram_wea(s_wea),
        .subgraph_bram_addra(s_addr),
        .h_data_bram_load_done(h_ld), .h_node_info_bram_load_done(n_ld), .wgt_bram_load_done(w_ld),
        .core_ready(core_ready), .sts_busy(sts_busy), .sts_done(sts_done), .sts_err(sts_err),
        .sts_err_code(sts_err_code), .dbg_state(dbg_state), .dbg_words(dbg_words), .dbg_cycles(dbg_cycles)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    logic [31:0] d_din[4], d_addr[4];
    logic [3:0]  d_ena, d_wea;
    logic [2:0]  d_ld;
    logic        out_any;
    assign d_din[0] = h_din;
    assign d_din[1] = n_din;
    assign d_din[2] = w_din;
    assign d_din[3] = s_din;
    assign d_addr[0] = 32'(h_addr);
    assign d_addr[1] = 32'(n_addr);
    assign d_addr[2] = 32'(w_addr);
    assign d_addr[3] = 32'(s_addr);
    assign d_ena = {s_ena, w_ena, n_ena, h_ena};
    assign d_wea = {s_wea, w_wea, n_wea, h_wea};
    assign d_ld  = {w_ld, n_ld, h_ld};
    assign out_any = |{host_ready, h_din, n_din, w_din, s_din, d_ena, d_wea, h_addr, n_addr, w_addr, s_addr,
                       d_ld, sts_busy, sts_done, sts_err, sts_err_code, dbg_state, dbg_words, dbg_cycles};

    // reference model: what the outputs must show in the cycle after each clock edge
    int          m_st, m_cnt[4], m_words, m_cycles, m_addr[4];
    logic [3:0]  m_wr;
    logic [31:0] m_din;
    logic [2:0]  m_ld;
    logic [1:0]  m_err;
    bit          m_prev_rdy, m_ok = 0;

    always @(posedge clk) begin : model
        int ns;
        bit acc, full, allfull, entering;
        if (!rst_n) begin
            m_st = IDLE; m_cnt = '{default: 0}; m_wr = 0; m_din = 0; m_addr = '{default: 0};
            m_ld = 0; m_err = 0; m_words = 0; m_cycles = 0; m_prev_rdy = 0; m_ok = 1;
        end else begin
            acc = m_st == LOAD && !cfg_abort && host_valid;
            full = m_cnt[host_sel] == dep[host_sel];
            allfull = 1;
            for (int r = 0; r < 4; r++) if (m_cnt[r] != dep[r]) allfull = 0;
            ns = m_st;
            if (cfg_abort) ns = IDLE;
            else if (m_st == LOAD) ns = (acc && full) ? ERR : allfull ? WAIT : LOAD;
            else if (m_st == WAIT) ns = (core_ready && !m_prev_rdy) ? DONE : (m_cycles == TIMEOUT - 1) ? ERR : WAIT;
            else if (cfg_start) ns = LOAD;
            entering = ns == LOAD && m_st != LOAD;
            m_wr = 0;
            if (acc && !full) begin
                m_wr[host_sel] = 1;
                m_din = host_data;
                m_addr[host_sel] = 4 * m_cnt[host_sel];
            end
            for (int r = 0; r < 3; r++)
                m_ld[r] = (ns == LOAD || ns == WAIT || ns == DONE) && !entering && m_cnt[r] == dep[r];
            if (entering || cfg_abort) m_cnt = '{default: 0};
            else if (acc && !full) m_cnt[host_sel]++;
            if (entering) m_words = 0; else if (acc) m_words++;
            if (entering) m_cycles = 0; else if (m_st == WAIT && ns == WAIT) m_cycles++;
            if (entering || cfg_abort) m_err = 0;
            else if (ns == ERR && m_st == LOAD) m_err = 1;
            else if (ns == ERR && m_st == WAIT) m_err = 2;
            m_prev_rdy = core_ready;
            m_st = ns;
        end
    end

    int last_wr[4] = '{default: -100}, ld_rise[3] = '{default: -100}, wr_cnt[4] = '{default: 0};
    int last_addr[4] = '{default: 0};
    int h_log[$];
    logic [2:0] prev_ld = 0;

    // per-cycle comparison against the model, plus write/load_done bookkeeping
    always @(negedge clk) if (m_ok) begin
        chk("host_ready", 32'(host_ready), 32'(m_st == LOAD && !cfg_abort));
        chk("ena", 32'(d_ena), 32'(m_wr));
        chk("wea", 32'(d_wea), 32'(m_wr));
        for (int r = 0; r < 4; r++) if (m_wr[r]) begin
            chk($sformatf("din%0d", r), d_din[r], m_din);
            chk($sformatf("addr%0d", r), d_addr[r], 32'(m_addr[r]));
        end
        chk("load_done", 32'(d_ld), 32'(m_ld));
        chk("status", 32'({sts_busy, sts_done, sts_err}),
            32'({m_st == LOAD || m_st == WAIT, m_st == DONE, m_st == ERR}));
        chk("err_code", 32'(sts_err_code), 32'(m_err));
        chk("state", 32'(dbg_state), 32'(m_st));
        chk("words", dbg_words, 32'(m_words));
        chk("cycles", dbg_cycles, 32'(m_cycles));
        for (int r = 0; r < 4; r++) if (d_ena[r]) begin
            last_wr[r] = cyc;
            wr_cnt[r]++;
            last_addr[r] = d_addr[r];
            if (r == 0) h_log.push_back(d_addr[0]);
        end
        for (int r = 0; r < 3; r++) if (d_ld[r] && !prev_ld[r]) ld_rise[r] = cyc;
        prev_ld = d_ld;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic [31:0] d);
        host_valid = 1;
        host_sel = 2'(s);
        host_data = d;
        tick();
        host_valid = 0;
    endtask

    task automatic pulse_start();
        cfg_start = 1;
        tick();
        cfg_start = 0;
    endtask

    task automatic load_seq(input logic [31:0] base);
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < dep[r]; i++) send(r, base + 32'(r * 256 + i));
    endtask

    task automatic wait_state(input int s, input int lim, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (dbg_state != 3'(s) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(dbg_state), 32'(s));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pat[4];
        int got[4];
        int n, t_w;
        pat = '{0, 2, 1, 3};
        // reset: all outputs zero
        tick();
        tick();
        @(negedge clk);
        chk("rst_outputs", 32'(out_any), 0);
        tick();
        rst_n = 1;
        tick();

        // test 1: sequential load
        h_log.delete();
        pulse_start();
        load_seq(32'h1000);
        wait_state(WAIT, 10, "t1_wait_core");
        chk("t1_hlog_n", 32'(h_log.size()), 5);
        for (int i = 0; i < 5; i++) chk("t1_haddr", 32'(h_log[i]), 32'(i * 4));
        for (int r = 0; r < 3; r++) chk("t1_ld_latency", 32'(ld_rise[r] - last_wr[r]), 1);
        chk("t1_words", dbg_words, 15);

        // test 3: core_ready rises 37 cycles after WAIT_CORE entry
        repeat (37) @(posedge clk);
        #1 core_ready = 1;
        wait_state(DONE, 5, "t3_done");
        chk("t3_sts_done", 32'(sts_done), 1);
        chk("t3_cycles", dbg_cycles, 37);
        chk("t3_load_done", 32'(d_ld), 7);

        // test 2: interleaved load 0,2,1,3 skipping full regions
        tick();
        core_ready = 0;
        tick();
        wr_cnt = '{default: 0};
        got = '{default: 0};
        n = 0;
        pulse_start();
        for (int rep = 0; rep < 8 && n < 15; rep++)
            for (int k = 0; k < 4; k++) if (got[pat[k]] < dep[pat[k]]) begin
                send(pat[k], 32'hA000 + 32'(n));
                got[pat[k]]++;
                n++;
            end
        wait_state(WAIT, 10, "t2_wait_core");
        chk("t2_words", dbg_words, 15);
        for (int r = 0; r < 4; r++) chk($sformatf("t2_wrcnt%0d", r), 32'(wr_cnt[r]), 32'(dep[r]));
        chk("t2_h_last_addr", 32'(last_addr[0]), 16);
        chk("t2_w_last_addr", 32'(last_addr[2]), 12);
        tick();
        pulse_start();
        @(negedge clk);
        chk("t2_start_ignored", 32'(dbg_state), WAIT);
        tick();
        cfg_abort = 1;
        tick();
        cfg_abort = 0;
        @(negedge clk);
        chk("t2_abort_idle", 32'(dbg_state), IDLE);
        chk("t2_abort_keeps_words", dbg_words, 15);

        // test 4: overflow of node_info
        tick();
        pulse_start();
        wr_cnt = '{default: 0};
        for (int i = 0; i < 4; i++) send(1, 32'hB000 + 32'(i));
        @(negedge clk);
        chk("t4_err_state", 32'(dbg_state), ERR);
        chk("t4_err_code", 32'(sts_err_code), 1);
        chk("t4_load_done", 32'(d_ld), 0);
        chk("t4_node_writes", 32'(wr_cnt[1]), 3);
        chk("t4_no_strobe", 32'(n_ena), 0);
        tick();
        pulse_start();
        @(negedge clk);
        chk("t4_reload", 32'(dbg_state), LOAD);
        chk("t4_words_clr", dbg_words, 0);

        // test 5: stale core_ready, timeout
        tick();
        core_ready = 1;
        load_seq(32'hC000);
        wait_state(WAIT, 10, "t5_wait_core");
        t_w = cyc;
        wait_state(ERR, 300, "t5_err");
        chk("t5_wait_len", 32'(cyc - t_w), 100);
        chk("t5_err_code", 32'(sts_err_code), 2);
        chk("t5_cycles", dbg_cycles, 99);

        // test 6: abort collides with a host word, then mid-load reset
        tick();
        core_ready = 0;
        pulse_start();
        send(0, 32'hD000);
        send(2, 32'hD001);
        host_valid = 1;
        host_sel = 1;
        host_data = 32'hD002;
        cfg_abort = 1;
        tick();
        host_valid = 0;
        cfg_abort = 0;
        @(negedge clk);
        chk("t6_no_strobe", 32'(d_ena), 0);
        chk("t6_idle", 32'(dbg_state), IDLE);
        tick();
        pulse_start();
        send(3, 32'hD003);
        host_valid = 1;
        host_sel = 0;
        rst_n = 0;
        tick();
        host_valid = 0;
        rst_n = 1;
        @(negedge clk);
        chk("t6_rst_outputs", 32'(out_any), 0);
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
